// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester memory port arbiter with in-order response routing
//
// Shares one req/gnt/rvalid memory port between instruction fetch and the LSU.
// Data requests have priority. A starvation counter forces a fetch grant after
// STARVE_LIMIT consecutive data grants while fetch waits. An owner FIFO records
// which side issued each outstanding access so in-order responses are routed back.
//
// Ports:
//   clk_i, rst_n_i                    clock, asynchronous active-low reset
//   instr_req_i/addr_i, instr_gnt_o   fetch request side
//   instr_rvalid_o/rdata_o            fetch response
//   data_req_i/addr_i/we_i/be_i/wdata_i, data_gnt_o   LSU request side
//   data_rvalid_o/rdata_o             LSU response
//   mem_req_o/addr_o/we_o/be_o/wdata_o, mem_gnt_i     memory request side
//   mem_rvalid_i/rdata_i              memory response (issue order)
//   busy_o                            transactions outstanding
//   resp_err_o                        sticky: response with nothing outstanding
module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    busy_o,
  output logic                    resp_err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = DATA_WIDTH / 8;

  localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [PW-1:0] PTR_LAST   = PW'(MAX_OUTSTANDING - 1);

  // Lock state: which side (if any) holds the port after an ungranted request.
  typedef enum logic [1:0] {
    ST_FREE       = 2'd0,
    ST_LOCK_INSTR = 2'd1,
    ST_LOCK_DATA  = 2'd2
  } lock_state_e;

  lock_state_e state_q, state_d;

  logic [MAX_OUTSTANDING-1:0] owner_q;
  logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]              count_q;
  logic [SW-1:0]              starve_cnt_q;
  logic                       resp_err_q;

  logic sel_instr, sel_data;
  logic starved, issue_ok;
  logic push, pop, head;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign starved  = (starve_cnt_q == STARVE_MAX);
  // Full check uses the registered count, so a pop never bypasses into issue.
  assign issue_ok = (count_q != CNT_MAX);

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_FREE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: an issued but ungranted request pins the selection until grant.
  always_comb begin
    state_d = ST_FREE;
    if (mem_req_o && !mem_gnt_i) begin
      state_d = sel_data ? ST_LOCK_DATA : ST_LOCK_INSTR;
    end
  end

  // Outputs: selection, request mux and grants
  always_comb begin
    sel_instr = 1'b0;
    sel_data  = 1'b0;
    case (state_q)
      ST_LOCK_INSTR: sel_instr = 1'b1;
      ST_LOCK_DATA:  sel_data  = 1'b1;
      default: begin
        sel_data  = data_req_i && !starved;
        sel_instr = instr_req_i && (starved || !data_req_i);
      end
    endcase

    mem_req_o   = issue_ok && (sel_instr || sel_data);
    instr_gnt_o = mem_req_o && sel_instr && mem_gnt_i;
    data_gnt_o  = mem_req_o && sel_data && mem_gnt_i;

    mem_addr_o  = sel_data ? data_addr_i : instr_addr_i;
    mem_we_o    = sel_data && data_we_i;
    mem_be_o    = sel_data ? data_be_i : {BW{1'b0}};
    mem_wdata_o = sel_data ? data_wdata_i : {DATA_WIDTH{1'b0}};
  end

  // Owner FIFO: 0 = instr, 1 = data
  assign push = instr_gnt_o || data_gnt_o;
  assign pop  = mem_rvalid_i && (count_q != '0);
  assign head = owner_q[rd_ptr_q];

  assign instr_rvalid_o = pop && !head;
  assign data_rvalid_o  = pop && head;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign busy_o         = (count_q != '0);
  assign resp_err_o     = resp_err_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      owner_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      resp_err_q <= 1'b0;
    end else begin
      if (push) begin
        owner_q[wr_ptr_q] <= data_gnt_o;
        wr_ptr_q          <= ptr_next(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (mem_rvalid_i && (count_q == '0)) begin
        resp_err_q <= 1'b1;
      end
    end
  end

  // Starvation counter: counts data wins while fetch is waiting.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      starve_cnt_q <= '0;
    end else if (!instr_req_i || instr_gnt_o) begin
      starve_cnt_q <= '0;
    end else if (data_gnt_o && !starved) begin
      starve_cnt_q <= starve_cnt_q + SW'(1);
    end
  end

endmodule
